// File: rtl/id_ex_stage.sv
//==========================================================================
// id_ex_stage : ID->EX pipeline register with WB bypass and load-use bubble
// Rev 1.0
//==========================================================================
`default_nettype none

module id_ex_stage #(
   parameter int CTRL_W     = 16,
   parameter int MEM_RD_BIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [31:0]       id_pc,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [4:0]        rd_reg_1,
   output logic [4:0]        rd_reg_2,
   input  logic [31:0]       rd_data_1,
   input  logic [31:0]       rd_data_2,
   input  logic              wb_wr_en,
   input  logic [4:0]        wb_wr_reg,
   input  logic [31:0]       wb_wr_data,
   output logic              load_use_hazard,
   output logic              ex_valid,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [31:0]       ex_op_a,
   output logic [31:0]       ex_op_b,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl
);

   logic              r_valid;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic [31:0]       r_op_a;
   logic [31:0]       r_op_b;
   logic [31:0]       r_pc;
   logic [31:0]       r_imm;
   logic [CTRL_W-1:0] r_ctrl;

   logic [31:0]       w_op_a;
   logic [31:0]       w_op_b;
   logic              w_hazard;

   assign rd_reg_1 = id_rs1;
   assign rd_reg_2 = id_rs2;

   // The file's write lands on this same edge, so its read data is stale on a match.
   always_comb begin
      w_op_a = rd_data_1;
      if (id_rs1 == 5'd0)
         w_op_a = 32'd0;
      else if (wb_wr_en && (wb_wr_reg == id_rs1))
         w_op_a = wb_wr_data;
   end

   always_comb begin
      w_op_b = rd_data_2;
      if (id_rs2 == 5'd0)
         w_op_b = 32'd0;
      else if (wb_wr_en && (wb_wr_reg == id_rs2))
         w_op_b = wb_wr_data;
   end

   assign w_hazard = r_valid && r_ctrl[MEM_RD_BIT] && (r_rd != 5'd0) && id_valid &&
                     ((r_rd == id_rs1) || (r_rd == id_rs2));

   always_ff @(posedge clk) begin
      if (reset || flush || (!stall && w_hazard)) begin
         r_valid <= 1'b0;
         r_rs1   <= 5'd0;
         r_rs2   <= 5'd0;
         r_rd    <= 5'd0;
         r_op_a  <= 32'd0;
         r_op_b  <= 32'd0;
         r_pc    <= 32'd0;
         r_imm   <= 32'd0;
         r_ctrl  <= '0;
      end else if (!stall) begin
         r_valid <= id_valid;
         r_rs1   <= id_rs1;
         r_rs2   <= id_rs2;
         r_rd    <= id_rd;
         r_op_a  <= w_op_a;
         r_op_b  <= w_op_b;
         r_pc    <= id_pc;
         r_imm   <= id_imm;
         r_ctrl  <= id_ctrl;
      end
   end

   assign load_use_hazard = w_hazard;
   assign ex_valid        = r_valid;
   assign ex_rs1          = r_rs1;
   assign ex_rs2          = r_rs2;
   assign ex_rd           = r_rd;
   assign ex_op_a         = r_op_a;
   assign ex_op_b         = r_op_b;
   assign ex_pc           = r_pc;
   assign ex_imm          = r_imm;
   assign ex_ctrl         = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//==========================================================================
// tb_id_ex_stage : scoreboard bench for id_ex_stage with directed vectors
// Rev 1.0
//==========================================================================
`default_nettype none

module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [31:0] id_pc = '0, id_imm = '0;
   logic [15:0] id_ctrl = '0;
   logic [4:0]  rd_reg_1, rd_reg_2;
   logic [31:0] rd_data_1 = '0, rd_data_2 = '0;
   logic        wb_wr_en = 1'b0;
   logic [4:0]  wb_wr_reg = '0;
   logic [31:0] wb_wr_data = '0;
   logic        load_use_hazard;
   logic        ex_valid;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [31:0] ex_op_a, ex_op_b, ex_pc, ex_imm;
   logic [15:0] ex_ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.CTRL_W(16), .MEM_RD_BIT(0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
      .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
      .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
      .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_ctrl(ex_ctrl)
   );

   typedef struct {
      int          idx;
      logic        reset, stall, flush, id_valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc, imm;
      logic [15:0] ctrl;
      logic [31:0] rd1, rd2;
      logic        wb_en;
      logic [4:0]  wb_reg;
      logic [31:0] wb_data;
      logic        chk_hz, hz;
      logic        e_valid;
      logic [4:0]  e_rs1, e_rs2, e_rd;
      logic [31:0] e_a, e_b, e_pc, e_imm;
      logic [15:0] e_ctrl;
   } vec_t;

   vec_t sbq[$];
   int   vec_n = 0;

   function automatic vec_t blank();
      vec_t v;
      v = '{default: '0};
      v.chk_hz = 1'b1;
      return v;
   endfunction

   // Expected captured EX contents; operands are supplied by the caller.
   function automatic vec_t expect_cap(vec_t v, logic [31:0] a, logic [31:0] b);
      vec_t r = v;
      r.e_valid = v.id_valid;
      r.e_rs1   = v.rs1;
      r.e_rs2   = v.rs2;
      r.e_rd    = v.rd;
      r.e_pc    = v.pc;
      r.e_imm   = v.imm;
      r.e_ctrl  = v.ctrl;
      r.e_a     = a;
      r.e_b     = b;
      return r;
   endfunction

   function automatic vec_t keep(vec_t v, vec_t h);
      vec_t r = v;
      r.e_valid = h.e_valid; r.e_rs1 = h.e_rs1; r.e_rs2 = h.e_rs2;
      r.e_rd = h.e_rd; r.e_pc = h.e_pc; r.e_imm = h.e_imm;
      r.e_ctrl = h.e_ctrl; r.e_a = h.e_a; r.e_b = h.e_b;
      return r;
   endfunction

   task automatic drive(input vec_t v_in);
      vec_t v = v_in;
      @(negedge clk);
      v.idx      = vec_n;
      vec_n++;
      reset      = v.reset;
      stall      = v.stall;
      flush      = v.flush;
      id_valid   = v.id_valid;
      id_rs1     = v.rs1;
      id_rs2     = v.rs2;
      id_rd      = v.rd;
      id_pc      = v.pc;
      id_imm     = v.imm;
      id_ctrl    = v.ctrl;
      rd_data_1  = v.rd1;
      rd_data_2  = v.rd2;
      wb_wr_en   = v.wb_en;
      wb_wr_reg  = v.wb_reg;
      wb_wr_data = v.wb_data;
      sbq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL v%0d %s actual=%h expected=%h", idx, name, act, exp);
      end
   endtask

   // Monitor: hazard sampled mid-cycle after inputs settle, EX state after the edge.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk_hz) chk("hazard", e.idx, {31'd0, load_use_hazard}, {31'd0, e.hz});
            @(posedge clk);
            #1;
            chk("ex_valid", e.idx, {31'd0, ex_valid}, {31'd0, e.e_valid});
            chk("ex_ctrl",  e.idx, {16'd0, ex_ctrl}, {16'd0, e.e_ctrl});
            chk("ex_pc",    e.idx, ex_pc, e.e_pc);
            chk("ex_imm",   e.idx, ex_imm, e.e_imm);
            chk("ex_op_a",  e.idx, ex_op_a, e.e_a);
            chk("ex_op_b",  e.idx, ex_op_b, e.e_b);
            chk("ex_rd",    e.idx, {27'd0, ex_rd}, {27'd0, e.e_rd});
            chk("ex_rs1",   e.idx, {27'd0, ex_rs1}, {27'd0, e.e_rs1});
            chk("ex_rs2",   e.idx, {27'd0, ex_rs2}, {27'd0, e.e_rs2});
         end
      end
   end

   initial begin
      vec_t v, held;

      // Reset beats stall and flush; EX state is unknown before the first edge.
      v = blank(); v.reset = 1; v.stall = 1; v.flush = 1; v.id_valid = 1;
      v.pc = 32'h44; v.ctrl = 16'hFFFF; v.chk_hz = 0;
      drive(v);
      v.chk_hz = 1;
      drive(v);

      // First capture after release
      v = blank(); v.id_valid = 1; v.pc = 32'h4; v.rs1 = 1; v.rs2 = 2; v.rd = 3;
      v.imm = 32'h10; v.ctrl = 16'h0002; v.rd1 = 32'hA; v.rd2 = 32'hB;
      drive(expect_cap(v, 32'hA, 32'hB));

      // Writeback bypass on rs1
      v = blank(); v.id_valid = 1; v.pc = 32'h8; v.rs1 = 5; v.rs2 = 6; v.rd = 9;
      v.ctrl = 16'h0004; v.rd1 = 32'h1111_1111; v.rd2 = 32'h2222_2222;
      v.wb_en = 1; v.wb_reg = 5; v.wb_data = 32'hDEAD_BEEF;
      drive(expect_cap(v, 32'hDEAD_BEEF, 32'h2222_2222));
      v.wb_en = 0; v.pc = 32'hC;
      drive(expect_cap(v, 32'h1111_1111, 32'h2222_2222));

      // x0 reads zero even when writeback targets x0
      v = blank(); v.id_valid = 1; v.pc = 32'h10; v.rs1 = 3; v.rs2 = 0; v.rd = 4;
      v.ctrl = 16'h0008; v.rd1 = 32'h33; v.rd2 = 32'hFFFF_FFFF;
      v.wb_en = 1; v.wb_reg = 0; v.wb_data = 32'h1234_5678;
      drive(expect_cap(v, 32'h33, 32'h0));

      // Load to x7, then a consumer on rs2: bubble, then capture
      v = blank(); v.id_valid = 1; v.pc = 32'h14; v.rs1 = 1; v.rs2 = 2; v.rd = 7;
      v.ctrl = 16'h0001; v.rd1 = 32'h1; v.rd2 = 32'h2;
      drive(expect_cap(v, 32'h1, 32'h2));
      v = blank(); v.id_valid = 1; v.pc = 32'h18; v.rs1 = 4; v.rs2 = 7; v.rd = 8;
      v.ctrl = 16'h0010; v.rd1 = 32'h40; v.rd2 = 32'h70; v.hz = 1;
      drive(v);
      v.hz = 0;
      drive(expect_cap(v, 32'h40, 32'h70));

      // Load then an invalid ID slot: no hazard, id_valid=0 captured as-is
      v = blank(); v.id_valid = 1; v.pc = 32'h1C; v.rd = 9; v.ctrl = 16'h0001;
      drive(expect_cap(v, 32'h0, 32'h0));
      v = blank(); v.id_valid = 0; v.pc = 32'h20; v.rs1 = 9; v.ctrl = 16'h0020;
      v.rd1 = 32'h99;
      drive(expect_cap(v, 32'h99, 32'h0));

      // Capture pc 0x100, then stall 3 cycles with changing ID and a matching writeback
      v = blank(); v.id_valid = 1; v.pc = 32'h100; v.rs1 = 1; v.rs2 = 2; v.rd = 3;
      v.imm = 32'h5; v.ctrl = 16'h0040; v.rd1 = 32'hAAAA; v.rd2 = 32'hBBBB;
      held = expect_cap(v, 32'hAAAA, 32'hBBBB);
      drive(held);
      for (int i = 0; i < 3; i++) begin
         v = blank(); v.stall = 1; v.id_valid = 1; v.pc = 32'h200 + 32'(i);
         v.rs1 = 1; v.rs2 = 2; v.rd = 5'(10 + i); v.rd1 = 32'h5555 + 32'(i);
         v.rd2 = 32'h6666; v.ctrl = 16'h0100; v.wb_en = 1; v.wb_reg = 1;
         v.wb_data = 32'hCCCC;
         drive(keep(v, held));
      end
      v = blank(); v.stall = 1; v.flush = 1; v.id_valid = 1; v.pc = 32'h240;
      v.ctrl = 16'h0200;
      drive(v);

      // Load to x0 followed by a reader of x0
      v = blank(); v.id_valid = 1; v.pc = 32'h300; v.rd = 0; v.ctrl = 16'h0001;
      drive(expect_cap(v, 32'h0, 32'h0));
      v = blank(); v.id_valid = 1; v.pc = 32'h304; v.rs1 = 0; v.rs2 = 0; v.rd = 6;
      v.ctrl = 16'h0080;
      drive(expect_cap(v, 32'h0, 32'h0));

      // Reset while stalled
      v = blank(); v.reset = 1; v.stall = 1; v.id_valid = 1; v.pc = 32'h308;
      v.ctrl = 16'h0400;
      drive(v);

      // Load to x5; stall outranks the hazard, then the bubble, then capture
      v = blank(); v.id_valid = 1; v.pc = 32'h400; v.rs1 = 1; v.rd = 5;
      v.ctrl = 16'h0001; v.rd1 = 32'h77;
      held = expect_cap(v, 32'h77, 32'h0);
      drive(held);
      v = blank(); v.stall = 1; v.id_valid = 1; v.pc = 32'h404; v.rs1 = 5; v.rs2 = 1;
      v.rd = 2; v.ctrl = 16'h0800; v.rd1 = 32'h50; v.rd2 = 32'h10; v.hz = 1;
      drive(keep(v, held));
      v.stall = 0;
      drive(v);
      v.hz = 0;
      drive(expect_cap(v, 32'h50, 32'h10));

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0 pending vectors", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
